// File: rtl/risc_v_mike_lsu.sv
// Load/store unit between a RISC-V core and a single-ported word memory.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into errors.
module risc_v_mike_lsu #(
    parameter int DATA_MEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] data_mem_addr,
    output logic        data_mem_write,
    output logic [31:0] data_mem_wr_data,
    input  logic [31:0] data_mem_rd_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [1:0]  SIZE_ILL  = 2'b11;
    localparam logic [31:0] DEPTH_W   = 32'(DATA_MEM_DEPTH);

    state_t      state, state_nx;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        bad_access;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        bad_access = ({2'b00, req_addr[31:2]} >= DEPTH_W) || (req_size == SIZE_ILL);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == SIZE_HALF) && req_addr[0])
            bad_access = 1'b1;
        if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
            bad_access = 1'b1;
`endif
    end

    // NOTE: the state register uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nx       = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        data_mem_write = 1'b0;
        data_mem_addr  = {2'b00, idx_q};
        case (state)
            IDLE: begin
                req_ready     = 1'b1;
                data_mem_addr = '0;
                if (req_valid) begin
                    if (bad_access)
                        state_nx = RSP;
                    else if (req_write && (req_size == SIZE_WORD))
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = wr_q ? WR : RSP;
            WR: begin
                data_mem_write = 1'b1;
                state_nx       = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Lane selection and sign/zero extension of the word being read.
    always_comb begin
        case (lane_q)
            2'd0:    lane_byte = data_mem_rd_data[7:0];
            2'd1:    lane_byte = data_mem_rd_data[15:8];
            2'd2:    lane_byte = data_mem_rd_data[23:16];
            default: lane_byte = data_mem_rd_data[31:24];
        endcase
        lane_half = lane_q[1] ? data_mem_rd_data[31:16] : data_mem_rd_data[15:0];
        case (size_q)
            SIZE_BYTE: load_ext = {{24{~uns_q & lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_ext = {{16{~uns_q & lane_half[15]}}, lane_half};
            default:   load_ext = data_mem_rd_data;
        endcase
    end

    // Read-modify-write: only the addressed lane of the old word is replaced.
    always_comb begin
        merged = old_q;
        case (size_q)
            SIZE_BYTE: begin
                case (lane_q)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane_q[1])
                    merged[31:16] = wdata_q[15:0];
                else
                    merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                lane_q  <= req_addr[1:0];
                idx_q   <= req_addr[31:2];
                wdata_q <= req_wdata;
                err_q   <= bad_access;
                rdata_q <= '0;
            end
            if (state == RD) begin
                old_q <= data_mem_rd_data;
                if (!wr_q)
                    rdata_q <= load_ext;
            end
        end
    end

    assign rsp_rdata        = rdata_q;
    assign rsp_err          = err_q & rsp_valid;
    assign data_mem_wr_data = data_mem_write ? merged : '0;

endmodule

// File: tb/tb_risc_v_mike_lsu.sv
// Directed scoreboard bench for risc_v_mike_lsu with a behavioural word memory.
module tb_risc_v_mike_lsu;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] data_mem_addr;
    logic        data_mem_write;
    logic [31:0] data_mem_wr_data;
    logic [31:0] data_mem_rd_data;

    logic [31:0] mem [16];
    rsp_t        exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    risc_v_mike_lsu #(.DATA_MEM_DEPTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .data_mem_addr    (data_mem_addr),
        .data_mem_write   (data_mem_write),
        .data_mem_wr_data (data_mem_wr_data),
        .data_mem_rd_data (data_mem_rd_data)
    );

    always #5 clk = ~clk;

    assign data_mem_rd_data = (data_mem_addr < 32'd16) ? mem[data_mem_addr[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (data_mem_write && (data_mem_addr < 32'd16))
            mem[data_mem_addr[3:0]] <= data_mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch up to 6 cycles for the write strobe and response.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic exp_we, input logic [31:0] exp_waddr,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                           input logic exp_err);
        logic got_rsp;
        logic saw_we;
        rsp_t e;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got_rsp   = 1'b0;
        saw_we    = 1'b0;
        for (int c = 1; c <= 6 && !got_rsp; c++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(req_ready), 32'd0);
            if (data_mem_write) begin
                saw_we = 1'b1;
                check({tag, "_waddr"}, data_mem_addr, exp_waddr);
                check({tag, "_wdata"}, data_mem_wr_data, exp_wdata);
            end
            if (rsp_valid) begin
                got_rsp = 1'b1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_rdata"}, rsp_rdata, e.rdata);
                    check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
                end
                check({tag, "_lat"}, c, exp_lat);
            end
        end
        check({tag, "_rsp_seen"}, 32'(got_rsp), 32'd1);
        check({tag, "_we_seen"}, 32'(saw_we), 32'(exp_we));
    endtask

    initial begin
        logic saw_wr;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h1122_3344;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_we", 32'(data_mem_write), 32'd0);
        check("rst_addr", data_mem_addr, 32'd0);
        check("rst_wr_data", data_mem_wr_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word stores
        run_req("sw_deadbeef", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 2, 1'b1, 32'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("mem2_deadbeef", mem[2], 32'hDEAD_BEEF);
        run_req("sw_80ff", 1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF_1234, 2, 1'b1, 32'd2, 32'h80FF_1234, 32'h0, 1'b0);

        // Loads from 0x80FF_1234
        run_req("lb_s_0b", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0);
        run_req("lb_u_0b", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'h0000_0080, 1'b0);
        run_req("lb_s_09", 1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'h0000_0012, 1'b0);
        run_req("lh_s_0a", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b0);
        run_req("lh_u_08", 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'h0000_1234, 1'b0);
        run_req("lw_08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'h80FF_1234, 1'b0);

        // Sub-word stores (read-modify-write)
        run_req("sh_06", 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_ABCD, 3, 1'b1, 32'd1, 32'hABCD_3344, 32'h0, 1'b0);
        check("mem1_abcd", mem[1], 32'hABCD_3344);
        run_req("sb_0d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFF_FFA5, 3, 1'b1, 32'd3, 32'h0000_A500, 32'h0, 1'b0);

        // Errors: out of range, illegal size
        run_req("lw_oob", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        run_req("sw_oob", 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        run_req("size11", 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        run_req("lw_last", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        run_req("lw_mis_05", 1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        run_req("lh_mis_07", 1'b0, 2'b01, 1'b0, 32'h07, 32'h0, 1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
`else
        run_req("lw_mis_05", 1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'hABCD_3344, 1'b0);
        run_req("lh_mis_07", 1'b0, 2'b01, 1'b0, 32'h07, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'hFFFF_ABCD, 1'b0);
`endif

        // Reset during the WR cycle of a byte store abandons it
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h04; req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        saw_wr = 1'b0;
        for (int c = 0; c < 4 && !saw_wr; c++) begin
            @(negedge clk);
            saw_wr = data_mem_write;
        end
        check("rstmid_reach_wr", 32'(saw_wr), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_we", 32'(data_mem_write), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_rsp", 32'(rsp_valid), 32'd0);
        check("rstmid_addr", data_mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_rsp", 32'(rsp_valid), 32'd0);
            check("post_rst_we", 32'(data_mem_write), 32'd0);
        end
        check("rstmid_mem1", mem[1], 32'hABCD_3344);

        // Normal operation resumes after reset
        run_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'h0000_A500, 1'b0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_v_mike_lsu.md
RISC_V_MIKE_LSU -- requirements
Module: risc_v_mike_lsu

Interface
REQ-001 SHALL have parameter DATA_MEM_DEPTH, default 16, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core access request.
REQ-005 SHALL have port req_ready  output  1  LSU can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend on load when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data.
REQ-013 SHALL have port rsp_err  output  1  access error, qualified by rsp_valid.
REQ-014 SHALL have port data_mem_addr  output  32  word index to data memory.
REQ-015 SHALL have port data_mem_write  output  1  memory write strobe.
REQ-016 SHALL have port data_mem_wr_data  output  32  full word written to memory.
REQ-017 SHALL have port data_mem_rd_data  input  32  combinational read data for data_mem_addr.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, RSP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept on req_valid & req_ready, latching all req_* fields; word index = req_addr[31:2], byte lane = req_addr[1:0].
REQ-020 SHALL go IDLE -> RSP with rsp_err=1, no memory write, for word index >= DATA_MEM_DEPTH or req_size = 11.
REQ-021 Load: IDLE -> RD -> RSP; in RD drive data_mem_addr, register lane-selected, extended data; rsp_valid two cycles after accept.
REQ-022 Word store: IDLE -> WR -> RSP; WR asserts data_mem_write for exactly one cycle with req_wdata.
REQ-023 Sub-word store: IDLE -> RD -> WR -> RSP; RD captures old word, WR writes old word with only the addressed byte/half replaced from req_wdata low bits.
REQ-024 RSP SHALL last one cycle then return to IDLE; no response back-pressure; stores return rsp_rdata = 0.
REQ-025 data_mem_write SHALL be 0 outside WR; data_mem_addr SHALL be 0 in IDLE, latched index in RD/WR/RSP.
REQ-026 Half-word lane = addr[1]; byte lane = addr[1:0]; sign bit = MSB of selected lane.
REQ-027 A req_valid arriving when req_ready = 0 SHALL be ignored (core holds it until accepted).

Reset
REQ-028 On rst: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, data_mem_write=0, data_mem_addr=0, data_mem_wr_data=0.
REQ-029 Reset mid-operation SHALL abandon the access; no write strobe and no response after rst deasserts.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 SHALL go IDLE -> RSP with rsp_err=1, no memory access.
REQ-031 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned low bits SHALL be ignored (half uses addr[1], word uses lane 0); no error.

Verification
REQ-032 Word store addr 0x08 data 0xDEADBEEF -> data_mem_write=1, data_mem_addr=2 one cycle; rsp_valid next cycle, rsp_err=0.
REQ-033 Signed byte load addr 0x0B, memory word 0x80FF_1234 -> rsp_rdata=0xFFFFFF80; unsigned -> 0x00000080; rsp_valid 2 cycles after accept.
REQ-034 Half store addr 0x06 data 0x0000ABCD over word 0x11223344 -> written word 0xABCD3344 at index 1.
REQ-035 Load addr 0x40 (index 16, depth 16) -> rsp_err=1, rsp_rdata=0, no write; also req_size=11 -> rsp_err=1.
REQ-036 Word load addr 0x05: with LSU_MISALIGN_TRAP_EN -> rsp_err=1; without -> word at index 1, rsp_err=0.
REQ-037 rst asserted in WR of a sub-word store -> data_mem_write=0 immediately, FSM IDLE, no rsp_valid.
